// File: rtl/aes_output_buffer.sv
`default_nettype none
// ============================================================================
// Module   : aes_output_buffer
// Brief    : Captures finished 128-bit AES plaintext blocks into a small FIFO
//            and streams them out as four 32-bit words over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module aes_output_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     data_done,
    input  logic [127:0]             data_output,
    output logic                     is_full,
    output logic [31:0]              o_word,
    output logic                     o_word_valid,
    input  logic                     i_word_ready,
    output logic                     o_word_last,
    output logic [$clog2(DEPTH):0]   o_block_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_COUNT = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    logic [127:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [1:0]           r_idx;

    logic                 w_full;
    logic                 w_valid;
    logic                 w_push;
    logic                 w_accept;
    logic                 w_pop;
    logic [127:0]         w_head;

    // All status outputs decode registered state only, so neither handshake
    // input has a combinational path to any output.
    assign w_full   = (r_count == c_FULL_COUNT);
    assign w_valid  = (r_count != '0);
    assign w_push   = data_done & ~w_full;
    assign w_accept = w_valid & i_word_ready;
    assign w_pop    = w_accept & (r_idx == 2'd3);

    assign is_full       = w_full;
    assign o_word_valid  = w_valid;
    assign o_word_last   = w_valid & (r_idx == 2'd3);
    assign o_block_count = r_count;

    always_comb begin
        w_head = r_mem[r_rd_ptr];
        o_word = w_head[127:96];
        case (r_idx)
            2'd0:    o_word = w_head[127:96];
            2'd1:    o_word = w_head[95:64];
            2'd2:    o_word = w_head[63:32];
            default: o_word = w_head[31:0];
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_idx    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_output;
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end

            if (w_accept) begin
                if (r_idx == 2'd3) begin
                    r_idx    <= 2'd0;
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end else begin
                    r_idx <= r_idx + 2'd1;
                end
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/aes_output_buffer.md
# aes_output_buffer

Downstream stage of the AES decryption pipeline. It captures each finished 128-bit plaintext block when the pipeline flags completion and holds it in a small FIFO. It drives the pipeline's stall input when that FIFO is full, and streams stored blocks out as four 32-bit words over a valid/ready handshake.

## Interface
- DEPTH, 4, number of 128-bit block entries; power of two, ≥2.
- clk  input  1  system clock, all state updates on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- data_done  input  1  pipeline output block is complete this cycle.
- data_output  input  128  finished plaintext block, valid when data_done=1.
- is_full  output  1  FIFO holds DEPTH blocks; wired to the pipeline stall input.
- o_word  output  32  current output word.
- o_word_valid  output  1  o_word holds valid data.
- i_word_ready  input  1  consumer accepts o_word this cycle.
- o_word_last  output  1  o_word is the 4th (final) word of its block.
- o_block_count  output  $clog2(DEPTH)+1  blocks currently stored, including a partially sent head block.

## Operation
- Storage: DEPTH×128 register array, write pointer, read pointer (each $clog2(DEPTH) bits, wrap modulo DEPTH), block count, 2-bit word index.
- Push: when data_done=1 and is_full=0, write data_output at the write pointer, then advance the write pointer.
- When data_done=1 and is_full=1, nothing is written. The pipeline is frozen by is_full, so data_done and data_output stay constant until space frees. The block is captured exactly once, on the first edge where is_full=0.
- is_full = (count == DEPTH), decoded from the count register only.
- Serializer: o_word_valid = (count != 0).
- o_word = head[127-32*idx -: 32], most-significant word first (idx 0 → bits 127:96).
- o_word_last = o_word_valid & (idx == 3).
- Accept: on o_word_valid & i_word_ready, idx increments. When idx==3, pop instead: idx returns to 0, the read pointer advances, and count decrements.
- Simultaneous push and pop: both pointers advance and count is unchanged.
- Push while full and pop in the same cycle: the push is refused, because is_full was 1 that cycle. The held block is taken on the next edge.
- Idle consumer: o_word/o_word_valid hold steady until accepted. Words are never skipped or repeated.
- Empty: o_word_valid=0, o_word_last=0. o_word is don't-care; implementations drive the stale array entry.
- No combinational path from i_word_ready or data_done to any output.

## Timing
- Reset (n_rst=0, asynchronous):
  - pointers, count and idx = 0.
  - is_full=0, o_word_valid=0, o_word_last=0, o_block_count=0.
  - o_word = 0; array cleared.
- Reset mid-transfer drops all stored and partially sent blocks. The first word after reset is word 0 of the next captured block.
- Capture latency: block pushed at edge N gives o_word_valid=1 and word 0 on o_word in cycle N+1.
- Throughput: with i_word_ready held 1, one word per cycle and one block per 4 cycles.
- is_full rises the cycle after the push that fills the FIFO. It falls the cycle after the pop of the 4th word of the head block.

## Test plan
- Single block: push 00112233_44556677_8899aabb_ccddeeff with ready=1 → o_word 00112233, 44556677, 8899aabb, ccddeeff on four consecutive cycles from N+1. o_word_last only on ccddeeff. Count returns to 0.
- Backpressure: ready=0 for 5 cycles mid-block (after word 1) → o_word stays 44556677 and valid stays 1. On resume, 8899aabb then ccddeeff follow, with no duplicates.
- Fill/stall: DEPTH=4, ready=0, push blocks B0..B3, then hold data_done=1 with B4 → is_full=1 and count=4. B4 is not written. Release ready → after 4 accepts, is_full=0 and B4 is captured exactly once. Output order is B0..B4.
- Simultaneous push/pop: count=2, push on the same edge as the last-word pop → count stays 2, and pointer wrap past DEPTH-1 keeps FIFO order.
- Reset mid-operation: 3 blocks stored, idx=2, assert n_rst=0 asynchronously → all outputs 0 immediately. After release, push X → first word equals X[127:96].
- Randomized data_done/ready for 10k cycles against a scoreboard queue → no loss, duplication or reordering. is_full = (count==DEPTH) every cycle.
